rr_mux8_way: RTL and testbench

//  Eight-channel packet merger: funnels eight valid/ready input streams onto one output

---
 rtl/rr_mux8_pkg.sv | 15 +
 rtl/rr_mux8_way_pick.sv | 28 ++
 rtl/rr_mux8_way.sv | 118 +++++++++++
 tb/tb_rr_mux8_way.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/rr_mux8_pkg.sv
// Shared types and sizes for the eight-channel packet merger.
// Used by the merger and by its rotating-priority picker.
package rr_mux8_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/rr_mux8_way_pick.sv
// Combinational rotating-priority picker: first requester at or after ptr wins.
// Used by rr_mux8_way to choose the next packet source while idle.
module rr_pick8
  import rr_mux8_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  sel_t              ptr,
  output sel_t              grant,
  output logic              any
);

  logic [2*NUM_CH-1:0] dbl_s;
  logic [NUM_CH-1:0]   rot_s;
  sel_t                off_s;

  // Rotate so bit 0 is channel ptr, then take the lowest set bit as an offset.
  always_comb begin
    dbl_s = {req, req} >> ptr;
    rot_s = dbl_s[NUM_CH-1:0];
    off_s = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      off_s = rot_s[k] ? sel_t'(k) : off_s;
    end
    grant = ptr + off_s;
    any   = |req;
  end

endmodule

// File: rtl/rr_mux8_way.sv
// Eight-channel packet merger with packet-level round-robin arbitration.
// Each output word carries the 3-bit source index a downstream 8-way demux needs.
module rr_mux8_way
  import rr_mux8_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH-1:0]       in_last,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready
);

  state_t             state_r;
  sel_t               ptr_r;
  sel_t               lock_sel_r;
  logic [WIDTH-1:0]   out_data_r;
  sel_t               out_sel_r;
  logic               out_last_r;
  logic               out_valid_r;

  sel_t               pick_grant_s;
  logic               pick_any_s;
  sel_t               grant_s;
  logic               grant_ok_s;
  logic               load_s;
  logic [NUM_CH-1:0]  in_ready_s;
  logic               xfer_s;
  logic               xfer_last_s;
  logic [WIDTH-1:0]   xfer_data_s;

  rr_pick8 u_pick (
    .req   (in_valid),
    .ptr   (ptr_r),
    .grant (pick_grant_s),
    .any   (pick_any_s)
  );

  // Grant selection and ready decode; a locked packet owns the output until its last word.
  always_comb begin
    load_s = !out_valid_r || out_ready;
    case (state_r)
      IDLE: begin
        grant_s    = pick_grant_s;
        grant_ok_s = pick_any_s;
      end
      LOCKED: begin
        grant_s    = lock_sel_r;
        grant_ok_s = 1'b1;
      end
      default: begin
        grant_s    = '0;
        grant_ok_s = 1'b0;
      end
    endcase
    if (load_s && grant_ok_s) begin
      in_ready_s = {{(NUM_CH-1){1'b0}}, 1'b1} << grant_s;
    end else begin
      in_ready_s = '0;
    end
    xfer_s      = |(in_valid & in_ready_s);
    xfer_last_s = in_last[grant_s];
    xfer_data_s = in_data[grant_s*WIDTH +: WIDTH];
  end

  // Output register and arbitration state; everything freezes while the output is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      ptr_r       <= '0;
      lock_sel_r  <= '0;
      out_data_r  <= '0;
      out_sel_r   <= '0;
      out_last_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (load_s) begin
      if (xfer_s) begin
        out_data_r  <= xfer_data_s;
        out_sel_r   <= grant_s;
        out_last_r  <= xfer_last_s;
        out_valid_r <= 1'b1;
        case (state_r)
          IDLE: begin
            if (xfer_last_s) begin
              ptr_r <= grant_s + 3'd1;
            end else begin
              state_r    <= LOCKED;
              lock_sel_r <= grant_s;
            end
          end
          LOCKED: begin
            if (xfer_last_s) begin
              state_r <= IDLE;
              ptr_r   <= lock_sel_r + 3'd1;
            end
          end
          default: state_r <= IDLE;
        endcase
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_r;
  assign out_sel   = out_sel_r;
  assign out_last  = out_last_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_rr_mux8_way.sv
// Directed table-driven bench for rr_mux8_way plus hand-written reset sequence.
// Channel i word = {tag, 5'b0, i}; a channel's tag changes only after its word is accepted.
module tb_rr_mux8_way;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [8*W-1:0] in_data;
  logic [7:0]     in_valid;
  logic [7:0]     in_last;
  logic [7:0]     in_ready;
  logic [W-1:0]   out_data;
  logic [2:0]     out_sel;
  logic           out_last;
  logic           out_valid;
  logic           out_ready;

  int checks = 0;
  int errors = 0;
  logic [7:0] ch_tag [8];

  typedef struct packed {
    logic [7:0] v;
    logic [7:0] l;
    logic       ordy;
    logic [7:0] upd;
    logic [7:0] tag;
    logic [7:0] erdy;
    logic       eov;
    logic [2:0] esel;
    logic       elast;
    logic [7:0] etag;
  } vec_t;

  vec_t vecs[$];

  rr_mux8_way #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] word(input logic [7:0] t, input logic [2:0] s);
    return {t, 5'b00000, s};
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input logic [7:0] v, input logic [7:0] l, input logic ordy,
                       input logic [7:0] upd, input logic [7:0] tag);
    for (int i = 0; i < 8; i++) begin
      if (upd[i]) ch_tag[i] = tag;
      in_data[i*W +: W] = word(ch_tag[i], 3'(i));
    end
    in_valid  = v;
    in_last   = l;
    out_ready = ordy;
  endtask

  task automatic add(input logic [7:0] v, input logic [7:0] l, input logic ordy,
                     input logic [7:0] upd, input logic [7:0] tag, input logic [7:0] erdy,
                     input logic eov, input logic [2:0] esel, input logic elast,
                     input logic [7:0] etag);
    vec_t t;
    t.v = v; t.l = l; t.ordy = ordy; t.upd = upd; t.tag = tag;
    t.erdy = erdy; t.eov = eov; t.esel = esel; t.elast = elast; t.etag = etag;
    vecs.push_back(t);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ch_tag[i] = 8'h00;
    reset = 1'b1;
    apply(8'h00, 8'h00, 1'b1, 8'hFF, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 0, out_valid, 1'b0);
    chk("rst_data",  0, out_data,  16'h0000);
    chk("rst_sel",   0, out_sel,   3'd0);
    chk("rst_last",  0, out_last,  1'b0);
    reset = 1'b0;

    // Move ptr to 6, then lock on ch3 so reset has real state to discard.
    apply(8'h20, 8'h20, 1'b1, 8'h20, 8'h01);
    @(posedge clk); #1;
    chk("pre_sel", 0, out_sel, 3'd5);
    apply(8'h08, 8'h00, 1'b1, 8'h08, 8'h02);
    @(posedge clk); #1;
    chk("pre_valid", 1, out_valid, 1'b1);
    chk("pre_sel",   1, out_sel,   3'd3);
    chk("pre_last",  1, out_last,  1'b0);
    chk("pre_data",  1, out_data,  word(8'h02, 3'd3));
    apply(8'h08, 8'h00, 1'b1, 8'h08, 8'h03);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", 1, out_valid, 1'b0);
    chk("mid_rst_data",  1, out_data,  16'h0000);
    chk("mid_rst_sel",   1, out_sel,   3'd0);
    chk("mid_rst_last",  1, out_last,  1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Round-robin over all eight single-word packets, starting from ch0 after reset.
    for (int k = 0; k < 9; k++) begin
      add(8'hFF, 8'hFF, 1'b1, (k == 0) ? 8'hFF : 8'(1 << ((k - 1) % 8)), 8'(8'h20 + k),
          8'(1 << (k % 8)), 1'b1, 3'(k % 8), 1'b1, (k == 8) ? 8'h21 : 8'h20);
    end
    add(8'h00, 8'h00, 1'b1, 8'h00, 8'h29, 8'h00, 1'b0, 3'd0, 1'b1, 8'h21);
    // Lock: ch2 three-word packet while ch5 waits (ptr=1).
    add(8'h24, 8'h20, 1'b1, 8'h24, 8'h31, 8'h04, 1'b1, 3'd2, 1'b0, 8'h31);
    add(8'h24, 8'h20, 1'b1, 8'h04, 8'h32, 8'h04, 1'b1, 3'd2, 1'b0, 8'h32);
    add(8'h24, 8'h24, 1'b1, 8'h04, 8'h33, 8'h04, 1'b1, 3'd2, 1'b1, 8'h33);
    add(8'h20, 8'h20, 1'b1, 8'h00, 8'h34, 8'h20, 1'b1, 3'd5, 1'b1, 8'h31);
    // Locked-channel gap: ch6 drops valid for four cycles while ch1 is valid (ptr=6).
    add(8'h42, 8'h02, 1'b1, 8'h42, 8'h40, 8'h40, 1'b1, 3'd6, 1'b0, 8'h40);
    for (int k = 0; k < 4; k++) begin
      add(8'h02, 8'h02, 1'b1, 8'h00, 8'h41, 8'h40, 1'b0, 3'd6, 1'b0, 8'h40);
    end
    add(8'h42, 8'h42, 1'b1, 8'h40, 8'h45, 8'h40, 1'b1, 3'd6, 1'b1, 8'h45);
    add(8'h02, 8'h02, 1'b1, 8'h00, 8'h46, 8'h02, 1'b1, 3'd1, 1'b1, 8'h40);
    // Back-pressure: five stalled cycles with ch4 pending (ptr=2).
    add(8'h18, 8'h18, 1'b1, 8'h18, 8'h50, 8'h08, 1'b1, 3'd3, 1'b1, 8'h50);
    for (int k = 0; k < 5; k++) begin
      add(8'h10, 8'h10, 1'b0, 8'h00, 8'h51, 8'h00, 1'b1, 3'd3, 1'b1, 8'h50);
    end
    add(8'h10, 8'h10, 1'b1, 8'h00, 8'h52, 8'h10, 1'b1, 3'd4, 1'b1, 8'h50);
    add(8'h00, 8'h00, 1'b1, 8'h00, 8'h53, 8'h00, 1'b0, 3'd4, 1'b1, 8'h50);
    // Wrap: ptr to 7, only ch0 valid; then ch7 beats ch0 from ptr=1.
    add(8'h40, 8'h40, 1'b1, 8'h40, 8'h60, 8'h40, 1'b1, 3'd6, 1'b1, 8'h60);
    add(8'h01, 8'h01, 1'b1, 8'h01, 8'h61, 8'h01, 1'b1, 3'd0, 1'b1, 8'h61);
    add(8'h81, 8'h81, 1'b1, 8'h81, 8'h62, 8'h80, 1'b1, 3'd7, 1'b1, 8'h62);
    add(8'h01, 8'h01, 1'b1, 8'h00, 8'h63, 8'h01, 1'b1, 3'd0, 1'b1, 8'h62);
    add(8'h00, 8'h00, 1'b1, 8'h00, 8'h64, 8'h00, 1'b0, 3'd0, 1'b1, 8'h62);

    foreach (vecs[r]) begin
      apply(vecs[r].v, vecs[r].l, vecs[r].ordy, vecs[r].upd, vecs[r].tag);
      #3;
      chk("in_ready", r, in_ready, vecs[r].erdy);
      @(posedge clk); #1;
      chk("out_valid", r, out_valid, vecs[r].eov);
      chk("out_sel",   r, out_sel,   vecs[r].esel);
      chk("out_last",  r, out_last,  vecs[r].elast);
      chk("out_data",  r, out_data,  word(vecs[r].etag, vecs[r].esel));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
